// File: rtl/rmii_receive_frame_controller.sv
// Receive frame controller: delimits packaged RMII bytes into frames by idle gap,
// writes them into a slotted buffer and hands completed frames out as descriptors.
module rmii_receive_frame_controller #(
  parameter int         RECEIVE_QUE_SLOTS      = 4,
  parameter int         SLOT_ADDRESS_WIDTH     = 11,
  parameter int         MINIMUM_FRAME_BYTES    = 64,
  parameter int         MAXIMUM_FRAME_BYTES    = 1522,
  parameter logic [1:0] SPEED_CODE_100_MEGABIT = 2'd1,
  parameter logic [1:0] SPEED_CODE_10_MEGABIT  = 2'd0,
  parameter int         IDLE_CYCLES_100        = 12,
  parameter int         IDLE_CYCLES_10         = 120,
  parameter int         SLOT_INDEX_WIDTH       = (RECEIVE_QUE_SLOTS > 1) ? $clog2(RECEIVE_QUE_SLOTS) : 1
) (
  input  logic                                       i_clock,
  input  logic                                       i_reset,
  input  logic [8:0]                                 i_packaged_data,
  input  logic                                       i_packaged_data_valid,
  input  logic [1:0]                                 i_speed_code,
  output logic                                       o_buffer_write_enable,
  output logic [SLOT_INDEX_WIDTH+SLOT_ADDRESS_WIDTH-1:0] o_buffer_write_address,
  output logic [7:0]                                 o_buffer_write_data,
  output logic                                       o_frame_valid,
  input  logic                                       i_frame_ready,
  output logic [SLOT_INDEX_WIDTH-1:0]                o_frame_slot,
  output logic [SLOT_ADDRESS_WIDTH:0]                o_frame_length,
  input  logic                                       i_frame_release,
  output logic [15:0]                                o_runt_count,
  output logic [15:0]                                o_oversize_count,
  output logic [15:0]                                o_overflow_count,
  output logic [1:0]                                 o_debug_state
);

  localparam int LEN_WIDTH  = SLOT_ADDRESS_WIDTH + 1;
  localparam int CNT_WIDTH  = $clog2(RECEIVE_QUE_SLOTS + 1);
  localparam int IDLE_MAX   = (IDLE_CYCLES_10 > IDLE_CYCLES_100) ? IDLE_CYCLES_10 : IDLE_CYCLES_100;
  localparam int IDLE_WIDTH = $clog2(IDLE_MAX + 1);

  localparam logic [LEN_WIDTH-1:0]        MAX_LEN   = LEN_WIDTH'(MAXIMUM_FRAME_BYTES);
  localparam logic [LEN_WIDTH-1:0]        MIN_LEN   = LEN_WIDTH'(MINIMUM_FRAME_BYTES);
  localparam logic [LEN_WIDTH-1:0]        LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]        CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]        CNT_FULL  = CNT_WIDTH'(RECEIVE_QUE_SLOTS);
  localparam logic [SLOT_INDEX_WIDTH-1:0] SLOT_ONE  = SLOT_INDEX_WIDTH'(1);
  localparam logic [SLOT_INDEX_WIDTH-1:0] SLOT_LAST = SLOT_INDEX_WIDTH'(RECEIVE_QUE_SLOTS - 1);
  localparam logic [IDLE_WIDTH-1:0]       IDLE_ONE  = IDLE_WIDTH'(1);
  localparam logic [IDLE_WIDTH-1:0]       LIMIT_100 = IDLE_WIDTH'(IDLE_CYCLES_100 - 1);
  localparam logic [IDLE_WIDTH-1:0]       LIMIT_10  = IDLE_WIDTH'(IDLE_CYCLES_10 - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECEIVE = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [SLOT_INDEX_WIDTH-1:0]   r_write_slot;
  logic [SLOT_INDEX_WIDTH-1:0]   r_read_slot;
  logic [CNT_WIDTH-1:0]          r_pending;
  logic [CNT_WIDTH-1:0]          r_occupied;
  logic [LEN_WIDTH-1:0]          r_length;
  logic [LEN_WIDTH-1:0]          r_length_mem [RECEIVE_QUE_SLOTS];
  logic [1:0]                    r_frame_speed;
  logic [IDLE_WIDTH-1:0]         r_idle_counter;
  logic                          r_buffer_write_enable;
  logic [SLOT_INDEX_WIDTH+SLOT_ADDRESS_WIDTH-1:0] r_buffer_write_address;
  logic [7:0]                    r_buffer_write_data;
  logic [15:0]                   r_runt_count;
  logic [15:0]                   r_oversize_count;
  logic [15:0]                   r_overflow_count;

  logic                          w_first;
  logic                          w_full;
  logic [1:0]                    w_gap_speed;
  logic [IDLE_WIDTH-1:0]         w_idle_limit;
  logic                          w_gap;
  logic                          w_do_write;
  logic                          w_restart;
  logic                          w_commit;
  logic                          w_runt_inc;
  logic                          w_oversize_inc;
  logic                          w_overflow_inc;
  logic                          w_handshake;
  logic                          w_release;
  logic [SLOT_ADDRESS_WIDTH-1:0] w_write_offset;

  assign w_first     = i_packaged_data_valid && i_packaged_data[8];
  assign w_full      = (r_occupied == CNT_FULL);
  assign w_handshake = (r_pending != '0) && i_frame_ready;
  // Only slots already handed to the consumer can be released.
  assign w_release   = i_frame_release && (r_occupied > r_pending);

  // A discarded frame has no latched speed, so its gap follows the live code.
  always_comb begin
    w_gap_speed  = (r_state == S_DISCARD) ? i_speed_code : r_frame_speed;
    w_idle_limit = LIMIT_10;
    if (w_gap_speed == SPEED_CODE_100_MEGABIT) begin
      w_idle_limit = LIMIT_100;
    end else if (w_gap_speed == SPEED_CODE_10_MEGABIT) begin
      w_idle_limit = LIMIT_10;
    end
  end

  assign w_gap = !i_packaged_data_valid && (r_idle_counter == w_idle_limit);

  always_comb begin
    w_state_next   = r_state;
    w_do_write     = 1'b0;
    w_restart      = 1'b0;
    w_commit       = 1'b0;
    w_runt_inc     = 1'b0;
    w_oversize_inc = 1'b0;
    w_overflow_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_first) begin
          if (!w_full) begin
            w_do_write   = 1'b1;
            w_restart    = 1'b1;
            w_state_next = S_RECEIVE;
          end else begin
            w_overflow_inc = 1'b1;
            w_state_next   = S_DISCARD;
          end
        end
      end
      S_RECEIVE: begin
        if (i_packaged_data_valid) begin
          if (i_packaged_data[8]) begin
            w_runt_inc = 1'b1;
            w_do_write = 1'b1;
            w_restart  = 1'b1;
          end else if (r_length < MAX_LEN) begin
            w_do_write = 1'b1;
          end else begin
            w_oversize_inc = 1'b1;
            w_state_next   = S_DISCARD;
          end
        end else if (w_gap) begin
          if (r_length < MIN_LEN) begin
            w_runt_inc = 1'b1;
          end else begin
            w_commit = 1'b1;
          end
          w_state_next = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (w_gap) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_write_offset = w_restart ? '0 : r_length[SLOT_ADDRESS_WIDTH-1:0];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_length               <= '0;
      r_frame_speed          <= '0;
      r_idle_counter         <= '0;
      r_buffer_write_enable  <= 1'b0;
      r_buffer_write_address <= '0;
      r_buffer_write_data    <= '0;
    end else begin
      r_buffer_write_enable <= w_do_write;
      if (w_do_write) begin
        r_buffer_write_address <= {r_write_slot, w_write_offset};
        r_buffer_write_data    <= i_packaged_data[7:0];
      end
      if (w_restart) begin
        r_length      <= LEN_ONE;
        r_frame_speed <= i_speed_code;
      end else if (w_do_write) begin
        r_length <= r_length + LEN_ONE;
      end
      if (i_packaged_data_valid || (r_state == S_IDLE)) begin
        r_idle_counter <= '0;
      end else begin
        r_idle_counter <= r_idle_counter + IDLE_ONE;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_write_slot <= '0;
      r_read_slot  <= '0;
      r_pending    <= '0;
      r_occupied   <= '0;
      for (int i = 0; i < RECEIVE_QUE_SLOTS; i++) begin
        r_length_mem[i] <= '0;
      end
    end else begin
      if (w_commit) begin
        r_length_mem[r_write_slot] <= r_length;
        r_write_slot <= (r_write_slot == SLOT_LAST) ? '0 : r_write_slot + SLOT_ONE;
      end
      if (w_handshake) begin
        r_read_slot <= (r_read_slot == SLOT_LAST) ? '0 : r_read_slot + SLOT_ONE;
      end
      case ({w_commit, w_handshake})
        2'b10:   r_pending <= r_pending + CNT_ONE;
        2'b01:   r_pending <= r_pending - CNT_ONE;
        default: r_pending <= r_pending;
      endcase
      case ({w_commit, w_release})
        2'b10:   r_occupied <= r_occupied + CNT_ONE;
        2'b01:   r_occupied <= r_occupied - CNT_ONE;
        default: r_occupied <= r_occupied;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_runt_count     <= '0;
      r_oversize_count <= '0;
      r_overflow_count <= '0;
    end else begin
      if (w_runt_inc && (r_runt_count != 16'hFFFF)) begin
        r_runt_count <= r_runt_count + 16'd1;
      end
      if (w_oversize_inc && (r_oversize_count != 16'hFFFF)) begin
        r_oversize_count <= r_oversize_count + 16'd1;
      end
      if (w_overflow_inc && (r_overflow_count != 16'hFFFF)) begin
        r_overflow_count <= r_overflow_count + 16'd1;
      end
    end
  end

  assign o_buffer_write_enable  = r_buffer_write_enable;
  assign o_buffer_write_address = r_buffer_write_address;
  assign o_buffer_write_data    = r_buffer_write_data;
  assign o_frame_valid          = (r_pending != '0);
  assign o_frame_slot           = r_read_slot;
  assign o_frame_length         = r_length_mem[r_read_slot];
  assign o_runt_count           = r_runt_count;
  assign o_oversize_count       = r_oversize_count;
  assign o_overflow_count       = r_overflow_count;
  assign o_debug_state          = r_state;

endmodule
